fifo_mode_responder: RTL and testbench
======================================

Name: fifo_mode_responder

Overview:
- Cycle-accurate responder model of the memory core in FIFO mode (mode=1, tile_en=1, chaining off).
- Sits on the DUT side of the A-QED harness. It accepts the same write stream the aqed wrapper issues (data_in/wen_in) and answers read requests (ren_in) with data_out/valid_out and FIFO status.
- Used as a stand-in memory core to bring up and debug the aqed wrapper, and as a golden responder for equivalence checks against memory_core.

Parameters:
- DATA_W, 16, data word width.
- DEPTH_MAX, 64, physical storage entries; must be a power of two.
- CNT_W, 7, occupancy counter width; equals log2(DEPTH_MAX)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  global enable; when low, storage, pointers and count hold.
- flush  in  1  synchronous clear of pointers and count; storage contents not cleared.
- depth  in  16  configured capacity; quasi-static.
- almost_count  in  4  almost-full/almost-empty threshold.
- data_in  in  DATA_W  write data.
- wen_in  in  1  write request.
- ren_in  in  1  read request.
- data_out  out  DATA_W  read data.
- valid_out  out  1  data_out valid for this cycle.
- full  out  1  count == cap.
- empty  out  1  count == 0.
- almost_full  out  1  count >= cap - almost_count (saturating at 0).
- almost_empty  out  1  count <= almost_count.
- err_overflow  out  1  sticky; a write was attempted while full with no same-cycle read.
- err_underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Effective capacity cap = DEPTH_MAX if depth==0 or depth>DEPTH_MAX; otherwise cap = depth.
- State: wr_ptr, rd_ptr (log2(DEPTH_MAX) bits, wrap at cap, not at DEPTH_MAX), count (CNT_W bits), valid_out register, data_out register, two sticky error flags.
- Reset (reset=1, any clk_en): ptrs=0, count=0, data_out=0, valid_out=0, err_*=0.
- flush=1 with reset=0: ptrs=0, count=0, valid_out=0. data_out and err_* hold. flush acts regardless of clk_en and overrides wen_in/ren_in.
- clk_en=0: ptrs, count, storage and errors hold; valid_out=0 next cycle; data_out holds.
- Write accepted (wa) = wen_in & clk_en & (!full | ren_in). wa stores data_in at wr_ptr; wr_ptr advances mod cap.
- Read accepted (ra) = ren_in & clk_en & !empty. ra latches mem[rd_ptr] into data_out, sets valid_out=1 next cycle, and advances rd_ptr mod cap.
  - Read latency is exactly 1 cycle. When ra=0, valid_out=0 next cycle.
- Empty with wen_in & ren_in: write accepted, read rejected, no bypass. valid_out=0; err_underflow set.
- Full with wen_in & ren_in: both accepted. The read returns the oldest entry; the write lands in the freed slot; count is unchanged.
- count_next = count + wa - ra. It never exceeds cap and never goes below 0.
- Status outputs (full, empty, almost_*) are combinational from the registered count and cap.
- err_overflow sets when wen_in & clk_en & full & !ren_in. The write is dropped and the FIFO is unchanged.
- err_underflow sets when ren_in & clk_en & empty.
- Both error flags are cleared only by reset.
- Changing depth while count != 0 is illegal; behaviour is undefined until the next flush or reset.

Test Plan:
- Reset, then depth=4, almost_count=1; write 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles.
  -> full=1 and almost_full=1 after the 4th write; almost_full already high after the 3rd; empty=0.
- From full, read 4 times back-to-back.
  -> valid_out high for 4 cycles, each one cycle after its ren_in, data 0x0011, 0x0022, 0x0033, 0x0044; then empty=1 and almost_empty=1.
- depth=4, full; wen_in=ren_in=1 with data_in=0x00AA.
  -> data_out=0x0011 next cycle; count stays 4; subsequent reads return 0x0022, 0x0033, 0x0044, 0x00AA; err_overflow=0.
- Empty; wen_in=ren_in=1 with data_in=0x0005.
  -> valid_out=0 next cycle, count=1, err_underflow=1; next read returns 0x0005.
- Write 3 words, then flush=1 for one cycle with wen_in=1.
  -> count=0 and empty=1; the flush-cycle write is discarded; a read issued after flush sets err_underflow.
- depth=0 (cap=64); write 70 words.
  -> full after the 64th; err_overflow=1 from the 65th; reading all returns words 1..64 in order; wrap is exercised.

Source files
------------

// File: rtl/fifo_mode_responder.sv
// rtl/fifo_mode_responder.sv - FIFO-mode memory core responder with status and sticky error flags
module fifo_mode_responder #(
  parameter int DATA_W    = 16,
  parameter int DEPTH_MAX = 64,
  parameter int CNT_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [15:0]       depth,
  input  logic [3:0]        almost_count,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wen_in,
  input  logic              ren_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_overflow,
  output logic              err_underflow
);
  localparam int AW = $clog2(DEPTH_MAX);

  logic [DATA_W-1:0] mem [DEPTH_MAX];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, cap, ac_ext, af_thr;
  logic              wa, ra;

  // Out-of-range or zero depth falls back to the full physical storage.
  always_comb begin
    cap = CNT_W'(DEPTH_MAX);
    if (depth != 16'd0 && depth <= 16'(DEPTH_MAX))
      cap = depth[CNT_W-1:0];
  end

  always_comb begin
    ac_ext = CNT_W'(almost_count);
    af_thr = (cap > ac_ext) ? (cap - ac_ext) : '0;
  end

  assign full         = (count == cap);
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_thr);
  assign almost_empty = (count <= ac_ext);

  assign wa = wen_in & clk_en & (~full | ren_in) & ~flush & ~reset;
  assign ra = ren_in & clk_en & ~empty & ~flush & ~reset;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p, input logic [CNT_W-1:0] c);
    return (CNT_W'(p) == c - CNT_W'(1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (wa)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
    end else if (!clk_en) begin
      valid_out <= 1'b0;
    end else begin
      valid_out <= ra;
      if (ra) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= bump(rd_ptr, cap);
      end
      if (wa)
        wr_ptr <= bump(wr_ptr, cap);
      count <= count + CNT_W'(wa) - CNT_W'(ra);
      if (wen_in && full && !ren_in)
        err_overflow <= 1'b1;
      if (ren_in && empty)
        err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_mode_responder.sv
// tb/tb_fifo_mode_responder.sv - directed scoreboard bench for fifo_mode_responder
module tb_fifo_mode_responder;
  logic        clk = 1'b0;
  logic        reset, clk_en, flush, wen_in, ren_in;
  logic [15:0] depth, data_in, data_out;
  logic [3:0]  almost_count;
  logic        valid_out, full, empty, almost_full, almost_empty, err_overflow, err_underflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  int          mcap;
  logic        m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_mode_responder dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .depth(depth),
    .almost_count(almost_count), .data_in(data_in), .wen_in(wen_in), .ren_in(ren_in),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    int sz = mq.size();
    int thr = (mcap > int'(almost_count)) ? mcap - int'(almost_count) : 0;
    chk("full", full, sz == mcap);
    chk("empty", empty, sz == 0);
    chk("almost_full", almost_full, sz >= thr);
    chk("almost_empty", almost_empty, sz <= int'(almost_count));
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_underflow", err_underflow, m_unf);
  endtask

  task automatic set_depth(input logic [15:0] d);
    depth = d;
    mcap  = (d == 16'd0 || d > 16'd64) ? 64 : int'(d);
  endtask

  // One clock: drive at negedge, update the model, check #1 after the edge.
  task automatic step(input logic w, input logic r, input logic [15:0] d,
                      input logic fl = 1'b0, input logic ce = 1'b1);
    logic m_full, m_empty, m_wa, m_ra, exp_valid;
    @(negedge clk);
    wen_in = w; ren_in = r; data_in = d; flush = fl; clk_en = ce;
    m_full  = (mq.size() == mcap);
    m_empty = (mq.size() == 0);
    m_wa = w & ce & (~m_full | r) & ~fl;
    m_ra = r & ce & ~m_empty & ~fl;
    if (!fl && ce) begin
      if (w && m_full && !r) m_ovf = 1'b1;
      if (r && m_empty)      m_unf = 1'b1;
    end
    if (fl) mq.delete();
    else begin
      if (m_ra) exp_q.push_back(mq.pop_front());
      if (m_wa) mq.push_back(d);
    end
    exp_valid = m_ra;
    @(posedge clk);
    #1;
    chk("valid_out", valid_out, exp_valid);
    if (exp_valid) begin
      if (exp_q.size() == 0) chk("scoreboard_underrun", 1, 0);
      else chk("data_out", data_out, exp_q.pop_front());
    end
    chk_status();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wen_in = 1'b0; ren_in = 1'b0; flush = 1'b0; clk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; clk_en = 1'b1;
    mq.delete(); exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0; wen_in = 1'b0; ren_in = 1'b0;
    data_in = '0; almost_count = 4'd1;
    set_depth(16'd4);
    do_reset();
    chk("rst_data_out", data_out, 16'h0);
    chk("rst_valid_out", valid_out, 1'b0);
    chk_status();

    // Fill to capacity 4, then drain back to back.
    step(1, 0, 16'h0011);
    step(1, 0, 16'h0022);
    step(1, 0, 16'h0033);
    chk("af_after_3rd", almost_full, 1'b1);
    step(1, 0, 16'h0044);
    chk("full_after_4th", full, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0);
    step(0, 0, 16'h0);
    chk("empty_after_drain", empty, 1'b1);

    // Simultaneous read/write while full.
    step(1, 0, 16'h0011);
    step(1, 0, 16'h0022);
    step(1, 0, 16'h0033);
    step(1, 0, 16'h0044);
    step(1, 1, 16'h00AA);
    chk("rw_full_data", data_out, 16'h0011);
    chk("rw_full_stays_full", full, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0);
    chk("rw_full_last", data_out, 16'h00AA);
    chk("rw_full_no_ovf", err_overflow, 1'b0);

    // Simultaneous read/write while empty: no bypass.
    step(1, 1, 16'h0005);
    chk("rw_empty_unf", err_underflow, 1'b1);
    step(0, 1, 16'h0);
    chk("rw_empty_read", data_out, 16'h0005);

    // Flush discards contents and the flush-cycle write.
    do_reset();
    step(1, 0, 16'h0101);
    step(1, 0, 16'h0102);
    step(1, 0, 16'h0103);
    step(1, 0, 16'h0104, 1'b1);
    chk("flush_empty", empty, 1'b1);
    step(0, 1, 16'h0);
    chk("flush_unf", err_underflow, 1'b1);

    // clk_en low holds state and suppresses valid_out.
    step(1, 0, 16'h0201);
    step(1, 1, 16'h0202, 1'b0, 1'b0);
    step(0, 1, 16'h0);
    chk("ce_hold_data", data_out, 16'h0201);

    // depth=0 selects the full 64 entries; overflow and wrap.
    do_reset();
    set_depth(16'd0);
    almost_count = 4'd3;
    for (int i = 1; i <= 70; i++) begin
      step(1, 0, 16'(i));
      if (i == 64) chk("full_at_64", full, 1'b1);
    end
    chk("ovf_after_70", err_overflow, 1'b1);
    for (int i = 0; i < 20; i++) step(0, 1, 16'h0);
    for (int i = 1; i <= 20; i++) step(1, 0, 16'(16'h0100 + i));
    for (int i = 0; i < 65; i++) step(0, 1, 16'h0);
    chk("wrap_last", data_out, 16'h0114);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
